// File: rtl/leaf_search_scheduler_if.sv
// rtl/leaf_search_scheduler_if.sv - request, leaf-mem, kernel, sorter and done signals of the leaf-search scheduler
interface leaf_search_scheduler_if #(
  parameter int NUM_LEAVES = 64,
  parameter int ADDR_WIDTH = $clog2(NUM_LEAVES),
  parameter int MAX_LEAVES = 16,
  parameter int CNT_W      = $clog2(MAX_LEAVES + 1),
  parameter int QIDX_W     = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic [QIDX_W-1:0]     req_query_idx;
  logic [ADDR_WIDTH-1:0] req_leaf_base;
  logic [CNT_W-1:0]      req_num_leaves;
  logic                  mem_csb;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  k_query_valid;
  logic [ADDR_WIDTH-1:0] k_leaf_idx;
  logic                  k_dist_valid;
  logic                  rm_restart;
  logic                  s_valid_in;
  logic                  s_valid_out;
  logic                  done_valid;
  logic                  done_ready;
  logic [QIDX_W-1:0]     done_query_idx;
  logic                  done_err;
  logic                  busy;

  modport master (
    input  req_valid, req_query_idx, req_leaf_base, req_num_leaves,
    input  k_dist_valid, s_valid_out, done_ready,
    output req_ready, mem_csb, mem_addr, k_query_valid, k_leaf_idx,
    output rm_restart, s_valid_in, done_valid, done_query_idx, done_err, busy
  );

  modport slave (
    output req_valid, req_query_idx, req_leaf_base, req_num_leaves,
    output k_dist_valid, s_valid_out, done_ready,
    input  req_ready, mem_csb, mem_addr, k_query_valid, k_leaf_idx,
    input  rm_restart, s_valid_in, done_valid, done_query_idx, done_err, busy
  );
endinterface

// File: rtl/leaf_search_scheduler.sv
// rtl/leaf_search_scheduler.sv - sequences one query through leaf read, L2 kernel, running-min and sorter
// All outputs are registered from the next-state so they change on the same edge as the FSM.
module leaf_search_scheduler #(
  parameter int NUM_LEAVES = 64,
  parameter int ADDR_WIDTH = $clog2(NUM_LEAVES),
  parameter int MAX_LEAVES = 16,
  parameter int CNT_W      = $clog2(MAX_LEAVES + 1),
  parameter int QIDX_W     = 9,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst_n,
  leaf_search_scheduler_if.master bus
);
  localparam int                    TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      MAX_N     = CNT_W'(MAX_LEAVES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_LEAVES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_SORT, S_WAIT_SORT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]      n_lat, issue_cnt, ret_cnt, ret_cnt_nx, req_n;
  logic [QIDX_W-1:0]     q_lat;
  logic [TO_W-1:0]       to_cnt;
  logic                  accept, timed_out, issuing, err_nx;

  logic                  req_ready_q, req_ready_nx;
  logic                  busy_q, busy_nx;
  logic                  rm_restart_q, rm_restart_nx;
  logic                  mem_csb_q, mem_csb_nx;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nx;
  logic                  kq_valid_q, kq_valid_nx;
  logic [ADDR_WIDTH-1:0] k_leaf_idx_q, k_leaf_idx_nx;
  logic                  s_valid_in_q, s_valid_in_nx;
  logic                  done_valid_q, done_valid_nx;
  logic                  done_err_q, done_err_nx;
  logic [QIDX_W-1:0]     done_idx_q, done_idx_nx;

  assign accept    = (state == S_IDLE) && bus.req_valid;
  assign timed_out = (to_cnt == TO_LAST);
  assign issuing   = (state == S_ISSUE) && (state_nx == S_ISSUE);

  always_comb begin
    req_n = bus.req_num_leaves;
    if (bus.req_num_leaves == '0)
      req_n = CNT_W'(1);
    else if (bus.req_num_leaves > MAX_N)
      req_n = MAX_N;
  end

  // Returns saturate at N so late duplicates cannot overshoot the compare.
  always_comb begin
    ret_cnt_nx = ret_cnt;
    if ((state == S_ISSUE || state == S_DRAIN) && bus.k_dist_valid && ret_cnt != n_lat)
      ret_cnt_nx = ret_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    case (state)
      S_IDLE:      if (accept) state_nx = S_ISSUE;
      S_ISSUE:     if (issue_cnt == n_lat) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (ret_cnt_nx == n_lat) begin
          state_nx = S_SORT;
        end else if (!bus.k_dist_valid && timed_out) begin
          state_nx = S_DONE;
          err_nx   = 1'b1;
        end
      end
      S_SORT:      state_nx = S_WAIT_SORT;
      S_WAIT_SORT: begin
        if (bus.s_valid_out) begin
          state_nx = S_DONE;
        end else if (timed_out) begin
          state_nx = S_DONE;
          err_nx   = 1'b1;
        end
      end
      S_DONE:      if (bus.done_ready) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_nx  = (state_nx == S_IDLE);
    busy_nx       = (state_nx != S_IDLE);
    rm_restart_nx = accept;
    mem_csb_nx    = (state_nx != S_ISSUE);
    mem_addr_nx   = mem_addr_q;
    if (accept)
      mem_addr_nx = bus.req_leaf_base;
    else if (issuing)
      mem_addr_nx = (mem_addr_q == LAST_ADDR) ? '0 : mem_addr_q + 1'b1;
    // Kernel strobe trails the read by the one-cycle SRAM latency.
    kq_valid_nx   = !mem_csb_q;
    k_leaf_idx_nx = mem_addr_q;
    s_valid_in_nx = (state_nx == S_SORT);
    done_valid_nx = (state_nx == S_DONE);
    done_err_nx   = done_err_q;
    done_idx_nx   = done_idx_q;
    if (state != S_DONE && state_nx == S_DONE) begin
      done_err_nx = err_nx;
      done_idx_nx = q_lat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_lat     <= '0;
      q_lat     <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      ret_cnt <= ret_cnt_nx;
      if (accept) begin
        n_lat     <= req_n;
        q_lat     <= bus.req_query_idx;
        issue_cnt <= CNT_W'(1);
        ret_cnt   <= '0;
      end else if (issuing) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (state_nx != state)
        to_cnt <= '0;
      else if ((state == S_DRAIN && bus.k_dist_valid) || (state == S_WAIT_SORT && bus.s_valid_out))
        to_cnt <= '0;
      else if (state == S_DRAIN || state == S_WAIT_SORT)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rm_restart_q <= 1'b0;
      mem_csb_q    <= 1'b1;
      mem_addr_q   <= '0;
      kq_valid_q   <= 1'b0;
      k_leaf_idx_q <= '0;
      s_valid_in_q <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_idx_q   <= '0;
    end else begin
      req_ready_q  <= req_ready_nx;
      busy_q       <= busy_nx;
      rm_restart_q <= rm_restart_nx;
      mem_csb_q    <= mem_csb_nx;
      mem_addr_q   <= mem_addr_nx;
      kq_valid_q   <= kq_valid_nx;
      k_leaf_idx_q <= k_leaf_idx_nx;
      s_valid_in_q <= s_valid_in_nx;
      done_valid_q <= done_valid_nx;
      done_err_q   <= done_err_nx;
      done_idx_q   <= done_idx_nx;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.busy           = busy_q;
  assign bus.rm_restart     = rm_restart_q;
  assign bus.mem_csb        = mem_csb_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.k_query_valid  = kq_valid_q;
  assign bus.k_leaf_idx     = k_leaf_idx_q;
  assign bus.s_valid_in     = s_valid_in_q;
  assign bus.done_valid     = done_valid_q;
  assign bus.done_err       = done_err_q;
  assign bus.done_query_idx = done_idx_q;
endmodule

// File: tb/tb_leaf_search_scheduler.sv
// tb/tb_leaf_search_scheduler.sv - randomized self-checking bench for leaf_search_scheduler
// Cycle numbers are relative to the request cycle; a kernel echoes each query 3 cycles later.
module tb_leaf_search_scheduler;
  localparam int NUM_LEAVES = 64;
  localparam int MAX_LEAVES = 16;
  localparam int TIMEOUT    = 255;
  localparam int LIMIT      = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  initial forever #5 clk = ~clk;

  leaf_search_scheduler_if bus ();
  leaf_search_scheduler #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_query(input int base, input int num, input int drop_in, input int sdelay,
                           input int hold, input logic [8:0] qidx);
    int n, drop, cyc, nreads, nkq, nrm, rm_cyc, nsv, sv_cyc, sout_cyc, done_cyc;
    int exp_done, exp_nsv, exp_err, last_ref;
    int strobes[$];
    n        = (num == 0) ? 1 : ((num > MAX_LEAVES) ? MAX_LEAVES : num);
    drop     = (drop_in >= n) ? -1 : drop_in;
    // Reads at 1..n, queries at 2..n+1, returns at 5..n+4, DRAIN from n+1.
    if (drop < 0) begin
      exp_nsv  = 1;
      exp_err  = (sdelay < 0) ? 1 : 0;
      exp_done = (sdelay < 0) ? n + 6 + TIMEOUT : n + 6 + sdelay;
    end else begin
      exp_nsv  = 0;
      exp_err  = 1;
      last_ref = n;
      for (int i = 0; i < n; i++)
        if (i != drop && 5 + i > last_ref) last_ref = 5 + i;
      exp_done = last_ref + TIMEOUT + 1;
    end
    nreads = 0; nkq = 0; nrm = 0; rm_cyc = -1; nsv = 0; sv_cyc = -1; sout_cyc = -1; done_cyc = -1;
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid      = 1'b1;
    bus.req_query_idx  = qidx;
    bus.req_leaf_base  = 6'(base);
    bus.req_num_leaves = 5'(num);
    tick();
    cyc = 1;
    bus.req_valid = 1'b0;
    check("busy_accepted", bus.busy, 1);
    check("req_ready_busy", bus.req_ready, 0);
    while (done_cyc < 0 && cyc < LIMIT) begin
      if (bus.rm_restart) begin nrm++; rm_cyc = cyc; end
      if (!bus.mem_csb) begin
        if (nreads < n) begin
          check("mem_addr", bus.mem_addr, (base + nreads) % NUM_LEAVES);
          check("mem_cycle", cyc, 1 + nreads);
        end
        nreads++;
      end
      if (bus.k_query_valid) begin
        if (nkq < n) begin
          check("k_leaf_idx", bus.k_leaf_idx, (base + nkq) % NUM_LEAVES);
          check("kq_cycle", cyc, 2 + nkq);
        end
        if (nkq != drop) strobes.push_back(cyc + 3);
        nkq++;
      end
      if (bus.s_valid_in) begin
        nsv++;
        sv_cyc = cyc;
        if (sdelay >= 0) sout_cyc = cyc + sdelay;
      end
      if (bus.done_valid) done_cyc = cyc;
      bus.k_dist_valid = 1'b0;
      if (strobes.size() > 0 && strobes[0] == cyc) begin
        bus.k_dist_valid = 1'b1;
        void'(strobes.pop_front());
      end
      bus.s_valid_out = (cyc == sout_cyc);
      if (done_cyc < 0) begin
        tick();
        cyc++;
      end
    end
    bus.k_dist_valid = 1'b0;
    bus.s_valid_out  = 1'b0;
    check("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
    check("done_cycle", done_cyc, exp_done);
    check("done_err", bus.done_err, exp_err);
    check("done_query_idx", bus.done_query_idx, qidx);
    check("read_count", nreads, n);
    check("kq_count", nkq, n);
    check("rm_restart_count", nrm, 1);
    check("rm_restart_cycle", rm_cyc, 1);
    check("s_valid_in_count", nsv, exp_nsv);
    if (exp_nsv == 1) check("s_valid_in_cycle", sv_cyc, n + 5);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("done_held", bus.done_valid, 1);
      check("req_ready_held", bus.req_ready, 0);
      check("done_idx_held", bus.done_query_idx, qidx);
      check("done_err_held", bus.done_err, exp_err);
    end
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check("done_cleared", bus.done_valid, 0);
    check("req_ready_back", bus.req_ready, 1);
    check("busy_cleared", bus.busy, 0);
  endtask

  task automatic reset_mid_issue();
    bus.req_valid      = 1'b1;
    bus.req_query_idx  = 9'd77;
    bus.req_leaf_base  = 6'd10;
    bus.req_num_leaves = 5'd8;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    check("issuing_before_reset", bus.mem_csb, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mem_csb", bus.mem_csb, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_k_query_valid", bus.k_query_valid, 0);
    check("rst_done_valid", bus.done_valid, 0);
    for (int i = 0; i < 6; i++) begin
      bus.k_dist_valid = 1'b1;
      bus.s_valid_out  = i[0];
      tick();
      check("stray_busy", bus.busy, 0);
      check("stray_done", bus.done_valid, 0);
      check("stray_mem_csb", bus.mem_csb, 1);
    end
    bus.k_dist_valid = 1'b0;
    bus.s_valid_out  = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, num, drop, sdelay, hold;
    bus.req_valid      = 1'b0;
    bus.req_query_idx  = '0;
    bus.req_leaf_base  = '0;
    bus.req_num_leaves = '0;
    bus.k_dist_valid   = 1'b0;
    bus.s_valid_out    = 1'b0;
    bus.done_ready     = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_mem_csb", bus.mem_csb, 1);
    check("reset_mem_addr", bus.mem_addr, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_rm_restart", bus.rm_restart, 0);
    check("reset_k_query_valid", bus.k_query_valid, 0);
    check("reset_s_valid_in", bus.s_valid_in, 0);
    check("reset_done_valid", bus.done_valid, 0);
    check("reset_done_err", bus.done_err, 0);
    check("reset_done_idx", bus.done_query_idx, 0);

    run_query(5, 4, -1, 2, 0, 9'd17);
    run_query(62, 4, -1, 1, 0, 9'd300);
    run_query(20, 0, -1, 3, 0, 9'd1);
    run_query(40, 20, -1, 1, 1, 9'd511);
    run_query(30, 4, 2, 1, 0, 9'd42);
    run_query(7, 5, -1, 2, 10, 9'd99);
    run_query(60, 6, -1, 1, 0, 9'd100);
    reset_mid_issue();
    run_query(50, 3, -1, -1, 0, 9'd200);
    run_query(63, 1, 0, 1, 0, 9'd3);

    for (int t = 0; t < 25; t++) begin
      base   = $urandom_range(0, NUM_LEAVES - 1);
      num    = $urandom_range(0, 20);
      drop   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
      sdelay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 6));
      hold   = $urandom_range(0, 3);
      run_query(base, num, drop, sdelay, hold, 9'($urandom_range(0, 511)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
